spi_register_controller: RTL and testbench

- Transaction controller that sits behind the SPI secondary shift register and maps SPI frames onto a single-port register bank.
- Frame layout:
  - First received word is a command: MSB is R/W (1 = write), remaining bits are the start address.
  - Following words are burst data, with auto-incrementing address.
- Supplies the next word to shift out: a status word during the command byte, then read data.
- A frame is delimited by the chip-select line neg_enable.

---
 rtl/spi_ctrl_pkg.sv | 19 +
 rtl/cs_synchronizer.sv | 29 ++
 rtl/spi_register_controller.sv | 165 ++++++++++++++++
 tb/tb_spi_register_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI register-bank transaction controller.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    DRAIN,
    IDLE,
    CMD,
    WRITE,
    READ
  } state_e;

  localparam int unsigned DEFAULT_WORD_BITS   = 8;
  localparam int unsigned CMD_WRITE_BIT       = DEFAULT_WORD_BITS - 1;
  localparam logic [7:0]  DEFAULT_STATUS_WORD = 8'hA5;

  // Cycles DRAIN waits after reset so the synchroniser reflects the real pin.
  localparam int unsigned DRAIN_SETTLE_CYCLES = 2;

endpackage

// File: rtl/cs_synchronizer.sv
// Two-flop synchroniser for the raw chip-select pin; resets to the inactive level.
module cs_synchronizer (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/spi_register_controller.sv
// Maps SPI frames (command word + burst data) onto a single-port register bank
// and supplies the next word for the shift register to transmit.
module spi_register_controller
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned          WORD_BITS   = DEFAULT_WORD_BITS,
  parameter int unsigned          ADDR_BITS   = WORD_BITS - 1,
  parameter logic [WORD_BITS-1:0] STATUS_WORD = WORD_BITS'(DEFAULT_STATUS_WORD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 neg_enable,
  input  logic                 word_ready,
  input  logic [WORD_BITS-1:0] data_word_received,
  output logic [WORD_BITS-1:0] data_word_to_send,
  output logic [ADDR_BITS-1:0] reg_addr,
  output logic                 reg_wr_en,
  output logic [WORD_BITS-1:0] reg_wr_data,
  output logic                 reg_rd_en,
  input  logic [WORD_BITS-1:0] reg_rd_data,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned WR_BIT     = WORD_BITS - 1;
  localparam int unsigned SETTLE_W   = 2;
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(DRAIN_SETTLE_CYCLES);

  logic cs_sync;
  logic cs_active;

  cs_synchronizer u_cs_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (neg_enable),
    .sync_out (cs_sync)
  );

  assign cs_active = ~cs_sync;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [WORD_BITS-1:0] wr_data_q, wr_data_d;
  logic [WORD_BITS-1:0] tx_q, tx_d;
  logic                 wr_en_q, wr_en_d;
  logic                 rd_en_q, rd_en_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 inc_pend_q, inc_pend_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;

  // Next-state, strobe and datapath decode.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    tx_d         = tx_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    rd_pend_d    = rd_en_q;
    inc_pend_d   = 1'b0;
    frame_done_d = 1'b0;
    settle_d     = settle_q;

    // Post-write address bump lands the cycle after the write strobe.
    if (inc_pend_q) begin
      addr_d = addr_q + ADDR_BITS'(1);
    end

    if (rd_pend_q && (state_q == READ)) begin
      tx_d = reg_rd_data;
    end

    unique case (state_q)
      DRAIN: begin
        tx_d = STATUS_WORD;
        if (settle_q != SETTLE_DONE) begin
          settle_d = settle_q + SETTLE_W'(1);
        end else if (!cs_active) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        tx_d = STATUS_WORD;
        if (cs_active) begin
          state_d = CMD;
        end
      end
      CMD: begin
        if (word_ready) begin
          addr_d = data_word_received[ADDR_BITS-1:0];
          if (data_word_received[WR_BIT]) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
            rd_en_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (word_ready) begin
          wr_data_d  = data_word_received;
          wr_en_d    = 1'b1;
          inc_pend_d = 1'b1;
        end
      end
      READ: begin
        if (word_ready) begin
          addr_d  = addr_q + ADDR_BITS'(1);
          rd_en_d = 1'b1;
        end
      end
      default: begin
        state_d = DRAIN;
      end
    endcase

    // Frame end: any word arriving this same cycle was already processed above.
    if ((state_q inside {CMD, WRITE, READ}) && !cs_active) begin
      state_d      = IDLE;
      frame_done_d = 1'b1;
      tx_d         = STATUS_WORD;
    end

    busy_d = state_d inside {CMD, WRITE, READ};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= DRAIN;
      addr_q       <= '0;
      wr_data_q    <= '0;
      tx_q         <= STATUS_WORD;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_pend_q    <= 1'b0;
      inc_pend_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      settle_q     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      tx_q         <= tx_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      rd_pend_q    <= rd_pend_d;
      inc_pend_q   <= inc_pend_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      settle_q     <= settle_d;
    end
  end

  assign data_word_to_send = tx_q;
  assign reg_addr          = addr_q;
  assign reg_wr_en         = wr_en_q;
  assign reg_wr_data       = wr_data_q;
  assign reg_rd_en         = rd_en_q;
  assign busy              = busy_q;
  assign frame_done        = frame_done_q;

endmodule

// File: tb/tb_spi_register_controller.sv
// Directed self-checking bench for spi_register_controller with a behavioural register bank.
module tb_spi_register_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       neg_enable = 1'b1;
  logic       word_ready = 1'b0;
  logic [7:0] data_rx = 8'h00;
  logic [7:0] tx;
  logic [6:0] addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data = 8'h00;
  logic       busy;
  logic       frame_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_register_controller dut (
    .clk                (clk),
    .rst                (rst),
    .neg_enable         (neg_enable),
    .word_ready         (word_ready),
    .data_word_received (data_rx),
    .data_word_to_send  (tx),
    .reg_addr           (addr),
    .reg_wr_en          (wr_en),
    .reg_wr_data        (wr_data),
    .reg_rd_en          (rd_en),
    .reg_rd_data        (rd_data),
    .busy               (busy),
    .frame_done         (frame_done)
  );

  // Register bank with a registered read port; preload port used by the bench.
  logic [7:0] bank [128];
  logic       pre_we = 1'b0;
  logic [6:0] pre_addr = 7'h00;
  logic [7:0] pre_data = 8'h00;

  always @(posedge clk) begin
    if (pre_we) bank[pre_addr] <= pre_data;
    else if (wr_en) bank[addr] <= wr_data;
    if (rd_en) rd_data <= bank[addr];
  end

  // Strobe logger sampled mid-cycle.
  int         wr_cnt = 0, rd_cnt = 0, fd_cnt = 0, both_cnt = 0;
  logic [6:0] wr_addr_log [64];
  logic [7:0] wr_data_log [64];
  logic [6:0] rd_addr_log [64];

  always @(negedge clk) begin
    if (wr_en) begin
      wr_addr_log[wr_cnt % 64] <= addr;
      wr_data_log[wr_cnt % 64] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (rd_en) begin
      rd_addr_log[rd_cnt % 64] <= addr;
      rd_cnt <= rd_cnt + 1;
    end
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (wr_en && rd_en) both_cnt <= both_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    word_ready = 1'b1;
    data_rx    = w;
    tick(1);
    word_ready = 1'b0;
    tick(7);
  endtask

  task automatic cs_low();
    neg_enable = 1'b0;
    tick(5);
  endtask

  task automatic cs_high();
    neg_enable = 1'b1;
    tick(6);
  endtask

  task automatic preload(input logic [6:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick(1);
    pre_we   = 1'b0;
  endtask

  task automatic test_reset();
    int wb, rb, fb;
    rst = 1'b1; neg_enable = 1'b0; word_ready = 1'b0;
    tick(3);
    checks++; if (tx !== 8'hA5) begin errors++; $display("FAIL reset_tx: got %h expected a5", tx); end
    checks++; if (addr !== 7'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", addr); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
    checks++; if ({wr_en, rd_en, busy, frame_done} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags: got wr=%b rd=%b busy=%b fd=%b expected all 0", wr_en, rd_en, busy, frame_done); end
    // Released with CS still low: must stay in DRAIN and ignore the frame tail.
    rst = 1'b0;
    tick(4);
    wb = wr_cnt; rb = rd_cnt; fb = fd_cnt;
    send_word(8'h85);
    send_word(8'h11);
    checks++; if ((wr_cnt - wb) != 0 || (rd_cnt - rb) != 0) begin errors++;
      $display("FAIL drain_strobes: got wr=%0d rd=%0d expected 0 0", wr_cnt - wb, rd_cnt - rb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy: got %b expected 0", busy); end
    neg_enable = 1'b1;
    tick(6);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    cs_low();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cmd_busy: got %b expected 1", busy); end
    cs_high();
    checks++; if ((fd_cnt - fb) != 1) begin errors++; $display("FAIL empty_frame_done: got %0d expected 1", fd_cnt - fb); end
    checks++; if ((wr_cnt - wb) != 0 || (rd_cnt - rb) != 0) begin errors++;
      $display("FAIL empty_frame_access: got wr=%0d rd=%0d expected 0 0", wr_cnt - wb, rd_cnt - rb); end
  endtask

  task automatic test_write_burst();
    int wb, rb, fb;
    wb = wr_cnt; rb = rd_cnt; fb = fd_cnt;
    cs_low();
    send_word(8'h85);
    send_word(8'h11);
    send_word(8'h22);
    cs_high();
    checks++; if ((wr_cnt - wb) != 2) begin errors++; $display("FAIL wr_count: got %0d expected 2", wr_cnt - wb); end
    checks++; if (wr_addr_log[wb % 64] !== 7'h05 || wr_data_log[wb % 64] !== 8'h11) begin errors++;
      $display("FAIL wr_first: got %h=%h expected 05=11", wr_addr_log[wb % 64], wr_data_log[wb % 64]); end
    checks++; if (wr_addr_log[(wb + 1) % 64] !== 7'h06 || wr_data_log[(wb + 1) % 64] !== 8'h22) begin errors++;
      $display("FAIL wr_second: got %h=%h expected 06=22", wr_addr_log[(wb + 1) % 64], wr_data_log[(wb + 1) % 64]); end
    checks++; if (bank[5] !== 8'h11 || bank[6] !== 8'h22) begin errors++;
      $display("FAIL wr_bank: got %h %h expected 11 22", bank[5], bank[6]); end
    checks++; if ((rd_cnt - rb) != 0) begin errors++; $display("FAIL wr_no_read: got %0d expected 0", rd_cnt - rb); end
    checks++; if ((fd_cnt - fb) != 1) begin errors++; $display("FAIL wr_frame_done: got %0d expected 1", fd_cnt - fb); end
    checks++; if (busy !== 1'b0 || tx !== 8'hA5) begin errors++;
      $display("FAIL wr_end_state: got busy=%b tx=%h expected 0 a5", busy, tx); end
  endtask

  task automatic test_read_burst();
    int wb, rb, fb;
    preload(7'h10, 8'hAB);
    preload(7'h11, 8'hCD);
    preload(7'h12, 8'h5E);
    wb = wr_cnt; rb = rd_cnt; fb = fd_cnt;
    cs_low();
    checks++; if (tx !== 8'hA5) begin errors++; $display("FAIL rd_status: got %h expected a5", tx); end
    send_word(8'h10);
    checks++; if (tx !== 8'hAB) begin errors++; $display("FAIL rd_word0: got %h expected ab", tx); end
    send_word(8'h00);
    checks++; if (tx !== 8'hCD) begin errors++; $display("FAIL rd_word1: got %h expected cd", tx); end
    send_word(8'h00);
    checks++; if (tx !== 8'h5E) begin errors++; $display("FAIL rd_word2: got %h expected 5e", tx); end
    checks++; if ((rd_cnt - rb) != 3) begin errors++; $display("FAIL rd_count: got %0d expected 3", rd_cnt - rb); end
    checks++; if (rd_addr_log[rb % 64] !== 7'h10 || rd_addr_log[(rb + 1) % 64] !== 7'h11 ||
                  rd_addr_log[(rb + 2) % 64] !== 7'h12) begin errors++;
      $display("FAIL rd_addrs: got %h %h %h expected 10 11 12", rd_addr_log[rb % 64],
               rd_addr_log[(rb + 1) % 64], rd_addr_log[(rb + 2) % 64]); end
    cs_high();
    checks++; if (tx !== 8'hA5) begin errors++; $display("FAIL rd_end_tx: got %h expected a5", tx); end
    checks++; if ((fd_cnt - fb) != 1 || (wr_cnt - wb) != 0) begin errors++;
      $display("FAIL rd_end_counts: got fd=%0d wr=%0d expected 1 0", fd_cnt - fb, wr_cnt - wb); end
  endtask

  task automatic test_addr_wrap();
    int wb;
    wb = wr_cnt;
    cs_low();
    send_word(8'hFF);
    send_word(8'h3C);
    send_word(8'h4D);
    cs_high();
    checks++; if ((wr_cnt - wb) != 2) begin errors++; $display("FAIL wrap_count: got %0d expected 2", wr_cnt - wb); end
    checks++; if (wr_addr_log[wb % 64] !== 7'h7F || wr_data_log[wb % 64] !== 8'h3C) begin errors++;
      $display("FAIL wrap_first: got %h=%h expected 7f=3c", wr_addr_log[wb % 64], wr_data_log[wb % 64]); end
    checks++; if (wr_addr_log[(wb + 1) % 64] !== 7'h00 || wr_data_log[(wb + 1) % 64] !== 8'h4D) begin errors++;
      $display("FAIL wrap_second: got %h=%h expected 00=4d", wr_addr_log[(wb + 1) % 64], wr_data_log[(wb + 1) % 64]); end
    checks++; if (addr !== 7'h01) begin errors++; $display("FAIL wrap_final_addr: got %h expected 01", addr); end
  endtask

  task automatic test_coincident_end();
    int wb, fb;
    wb = wr_cnt; fb = fd_cnt;
    cs_low();
    send_word(8'h83);
    // Time word_ready to land on the clk where the synchronised CS first reads inactive.
    neg_enable = 1'b1;
    tick(2);
    word_ready = 1'b1;
    data_rx    = 8'h77;
    tick(1);
    word_ready = 1'b0;
    checks++; if (wr_en !== 1'b1 || frame_done !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL coinc_edge: got wr=%b fd=%b busy=%b expected 1 1 0", wr_en, frame_done, busy); end
    tick(4);
    checks++; if (bank[3] !== 8'h77) begin errors++; $display("FAIL coinc_commit: got %h expected 77", bank[3]); end
    checks++; if ((wr_cnt - wb) != 1 || (fd_cnt - fb) != 1) begin errors++;
      $display("FAIL coinc_counts: got wr=%0d fd=%0d expected 1 1", wr_cnt - wb, fd_cnt - fb); end
    checks++; if (tx !== 8'hA5) begin errors++; $display("FAIL coinc_tx: got %h expected a5", tx); end
  endtask

  task automatic test_reset_mid_read();
    int wb;
    preload(7'h20, 8'h99);
    cs_low();
    send_word(8'h20);
    checks++; if (tx !== 8'h99) begin errors++; $display("FAIL mid_rd_data: got %h expected 99", tx); end
    rst        = 1'b1;
    word_ready = 1'b1;
    data_rx    = 8'h00;
    tick(1);
    checks++; if ({wr_en, rd_en, busy, frame_done} !== 4'b0000) begin errors++;
      $display("FAIL mid_rd_reset_strobes: got wr=%b rd=%b busy=%b fd=%b expected all 0", wr_en, rd_en, busy, frame_done); end
    checks++; if (tx !== 8'hA5) begin errors++; $display("FAIL mid_rd_reset_tx: got %h expected a5", tx); end
    word_ready = 1'b0;
    rst        = 1'b0;
    tick(3);
    wb = wr_cnt;
    send_word(8'h85);
    send_word(8'h11);
    checks++; if ((wr_cnt - wb) != 0 || busy !== 1'b0) begin errors++;
      $display("FAIL mid_rd_drain: got wr=%0d busy=%b expected 0 0", wr_cnt - wb, busy); end
    neg_enable = 1'b1;
    tick(6);
    cs_low();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_rd_reframe_busy: got %b expected 1", busy); end
    send_word(8'h85);
    send_word(8'h11);
    cs_high();
    checks++; if ((wr_cnt - wb) != 1 || wr_addr_log[wb % 64] !== 7'h05 || wr_data_log[wb % 64] !== 8'h11) begin errors++;
      $display("FAIL mid_rd_reframe_write: got n=%0d %h=%h expected 1 05=11", wr_cnt - wb,
               wr_addr_log[wb % 64], wr_data_log[wb % 64]); end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_addr_wrap();
    test_coincident_end();
    test_reset_mid_read();
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL strobe_overlap: got %0d expected 0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
